// File: rtl/ex_pipe_if.sv
// ex_pipe_if
// Handshake and data bundle between decode, the ex_pipe execute stage and
// the memory stage.
//
// Configuration: WIDTH, the datapath width in bits.
//
// Decode side (driven by master):
//   in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i
//   in_ready (driven by slave)
// Memory side (driven by slave):
//   out_valid, icode_o, valE_o, valA_o, dstE_o, cnd_o, cc_o, err_o
//   out_ready (driven by master)
//
// Modports:
//   master - the environment around the stage (decode plus memory).
//   slave  - the execute stage itself.

interface ex_pipe_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [7:0]       icode_i;
   logic [7:0]       ifun_i;
   logic [WIDTH-1:0] valA_i;
   logic [WIDTH-1:0] valB_i;
   logic [WIDTH-1:0] valC_i;
   logic [7:0]       dstE_i;

   logic             out_valid;
   logic             out_ready;
   logic [7:0]       icode_o;
   logic [WIDTH-1:0] valE_o;
   logic [WIDTH-1:0] valA_o;
   logic [7:0]       dstE_o;
   logic             cnd_o;
   logic [2:0]       cc_o;
   logic             err_o;

   modport master (
      output in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i,
      output out_ready,
      input  in_ready,
      input  out_valid, icode_o, valE_o, valA_o, dstE_o, cnd_o, cc_o, err_o
   );

   modport slave (
      input  in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i,
      input  out_ready,
      output in_ready,
      output out_valid, icode_o, valE_o, valA_o, dstE_o, cnd_o, cc_o, err_o
   );

endinterface

// File: rtl/ex_pipe.sv
// ex_pipe
// Registered Y86 execute stage. It computes valE for every icode and updates
// the {ZF,SF,OF} condition-code register on OPL. It resolves cmovXX/jXX
// against the stored condition codes. Both sides use valid/ready handshakes.
//
// Parameters:
//   WIDTH - datapath width in bits. It must be a multiple of 8 and at least 16.
//   RNONE - register code that means "no destination".
//
// Ports:
//   clk - clock.
//   rst - synchronous, active-high reset.
//   bus - ex_pipe_if.slave. It carries the decode-side inputs, the
//         memory-side outputs and both handshakes.
//
// Optional feature, macro EX_MULL_EN:
//   When EX_MULL_EN is defined, OPL ifun 4 (MULL) runs as a one-bit-per-cycle
//   shift-add multiply. During the multiply the stage sits in state MUL.
//   When EX_MULL_EN is not defined, MULL is reported as an invalid
//   instruction, and every instruction completes in one cycle.

module ex_pipe #(
   parameter int         WIDTH = 32,
   parameter logic [7:0] RNONE = 8'h0F
) (
   input logic      clk,
   input logic      rst,
   ex_pipe_if.slave bus
);

   localparam logic [7:0] I_HALT   = 8'h00;
   localparam logic [7:0] I_NOP    = 8'h01;
   localparam logic [7:0] I_CMOVXX = 8'h02;
   localparam logic [7:0] I_IRMOVL = 8'h03;
   localparam logic [7:0] I_RMMOVL = 8'h04;
   localparam logic [7:0] I_MRMOVL = 8'h05;
   localparam logic [7:0] I_OPL    = 8'h06;
   localparam logic [7:0] I_JXX    = 8'h07;
   localparam logic [7:0] I_CALL   = 8'h08;
   localparam logic [7:0] I_RET    = 8'h09;
   localparam logic [7:0] I_PUSHL  = 8'h0A;
   localparam logic [7:0] I_POPL   = 8'h0B;

   localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);

   logic [2:0]       cc_q;
   logic             outValid_q;
   logic [7:0]       icode_q;
   logic [WIDTH-1:0] valE_q;
   logic [WIDTH-1:0] valA_q;
   logic [7:0]       dstE_q;
   logic             cnd_q;
   logic             err_q;

   logic             accept;
   logic             condOk;
   logic [WIDTH-1:0] resE;
   logic             resCnd;
   logic             resErr;
   logic [7:0]       resDst;
   logic             ofFlag;
   logic             ccWrite;
   logic [2:0]       cc_d;

`ifdef EX_MULL_EN
   typedef enum logic {IDLE, MUL} state_t;

   localparam int             CW         = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  COUNT_DONE = CW'(WIDTH);

   state_t             state_q;
   logic [CW-1:0]      count_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               isMull;
   logic [WIDTH-1:0]   mulLo;
   logic               mulHiNz;

   // A new instruction enters only when the FSM is idle and the output
   // register is empty or is being drained in the same cycle.
   assign bus.in_ready = (state_q == IDLE) && (!outValid_q || bus.out_ready);

   // The accumulator holds the full 2*WIDTH product after WIDTH iterations.
   assign mulLo   = acc_q[WIDTH-1:0];
   assign mulHiNz = |acc_q[2*WIDTH-1:WIDTH];
`else
   // A new instruction enters when the output register is empty or is being
   // drained in the same cycle, so back-to-back transfers keep full throughput.
   assign bus.in_ready = !outValid_q || bus.out_ready;
`endif

   assign accept = bus.in_valid && bus.in_ready;

   assign bus.out_valid = outValid_q;
   assign bus.icode_o   = icode_q;
   assign bus.valE_o    = valE_q;
   assign bus.valA_o    = valA_q;
   assign bus.dstE_o    = dstE_q;
   assign bus.cnd_o     = cnd_q;
   assign bus.cc_o      = cc_q;
   assign bus.err_o     = err_q;

   // This block decodes the incoming instruction into its result value,
   // condition outcome, destination, error flag and new condition codes.
   // It tests conditions against the committed cc register. A CC write made
   // on the previous edge is therefore already visible here. An error result
   // forces the result fields to their suppressed values and blocks the
   // CC write.
   always_comb begin
      condOk = 1'b0;
      case (bus.ifun_i)
         8'd0:    condOk = 1'b1;
         8'd1:    condOk = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         8'd2:    condOk = cc_q[1] ^ cc_q[0];
         8'd3:    condOk = cc_q[2];
         8'd4:    condOk = !cc_q[2];
         8'd5:    condOk = !(cc_q[1] ^ cc_q[0]);
         8'd6:    condOk = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
         default: condOk = 1'b0;
      endcase

      resE    = '0;
      resCnd  = 1'b1;
      resErr  = 1'b0;
      resDst  = bus.dstE_i;
      ofFlag  = 1'b0;
      ccWrite = 1'b0;
`ifdef EX_MULL_EN
      isMull  = 1'b0;
`endif

      case (bus.icode_i)
         I_HALT, I_NOP: resE = '0;
         I_CMOVXX: begin
            resE   = bus.valA_i;
            resCnd = condOk;
            resErr = (bus.ifun_i > 8'd6);
            if (!condOk) resDst = RNONE;
         end
         I_IRMOVL: resE = bus.valC_i;
         I_RMMOVL, I_MRMOVL: resE = bus.valB_i + bus.valC_i;
         I_OPL: begin
            ccWrite = 1'b1;
            case (bus.ifun_i)
               8'd0: begin
                  resE   = bus.valB_i + bus.valA_i;
                  ofFlag = (bus.valA_i[WIDTH-1] == bus.valB_i[WIDTH-1]) &&
                           (resE[WIDTH-1] != bus.valA_i[WIDTH-1]);
               end
               8'd1: begin
                  resE   = bus.valB_i - bus.valA_i;
                  ofFlag = (bus.valA_i[WIDTH-1] != bus.valB_i[WIDTH-1]) &&
                           (resE[WIDTH-1] != bus.valB_i[WIDTH-1]);
               end
               8'd2: resE = bus.valB_i & bus.valA_i;
               8'd3: resE = bus.valB_i ^ bus.valA_i;
`ifdef EX_MULL_EN
               8'd4: begin
                  isMull  = 1'b1;
                  ccWrite = 1'b0;
               end
`endif
               default: resErr = 1'b1;
            endcase
         end
         I_JXX: begin
            resE   = bus.valC_i;
            resCnd = condOk;
            resErr = (bus.ifun_i > 8'd6);
         end
         I_CALL, I_PUSHL: resE = bus.valB_i - STACK_STEP;
         I_RET, I_POPL:   resE = bus.valB_i + STACK_STEP;
         default: resErr = 1'b1;
      endcase

      if (resErr) begin
         resE    = '0;
         resDst  = RNONE;
         resCnd  = 1'b0;
         ccWrite = 1'b0;
      end

      cc_d = cc_q;
      if (ccWrite) cc_d = {(resE == '0), resE[WIDTH-1], ofFlag};
   end

   // This block holds the output register, the cc register and, when enabled,
   // the multiply FSM. A single-cycle instruction loads the output on the
   // edge that accepts it. A MULL records its pass-through fields on
   // acceptance. It loads valE, the flags and out_valid on the edge where
   // the counter reaches WIDTH. Reset wins over every transfer, so a reset
   // during a multiply discards it without touching cc.
   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         cc_q       <= 3'b100;
         icode_q    <= I_NOP;
         valE_q     <= '0;
         valA_q     <= '0;
         dstE_q     <= RNONE;
         cnd_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef EX_MULL_EN
         state_q    <= IDLE;
         count_q    <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
`endif
      end else begin
`ifdef EX_MULL_EN
         if (accept && !isMull) begin
`else
         if (accept) begin
`endif
            outValid_q <= 1'b1;
            icode_q    <= bus.icode_i;
            valE_q     <= resE;
            valA_q     <= bus.valA_i;
            dstE_q     <= resDst;
            cnd_q      <= resCnd;
            err_q      <= resErr;
            cc_q       <= cc_d;
         end else if (outValid_q && bus.out_ready) begin
            outValid_q <= 1'b0;
         end

`ifdef EX_MULL_EN
         case (state_q)
            IDLE: begin
               if (accept && isMull) begin
                  state_q  <= MUL;
                  count_q  <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, bus.valB_i};
                  mplier_q <= bus.valA_i;
                  acc_q    <= '0;
                  icode_q  <= bus.icode_i;
                  valA_q   <= bus.valA_i;
                  dstE_q   <= bus.dstE_i;
               end
            end
            MUL: begin
               if (count_q == COUNT_DONE) begin
                  state_q    <= IDLE;
                  count_q    <= '0;
                  outValid_q <= 1'b1;
                  valE_q     <= mulLo;
                  cnd_q      <= 1'b1;
                  err_q      <= 1'b0;
                  cc_q       <= {(mulLo == '0), mulLo[WIDTH-1], mulHiNz};
               end else begin
                  if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  count_q  <= count_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_ex_pipe.sv
// tb_ex_pipe
// Self-checking bench for ex_pipe (WIDTH=32). A reference model predicts
// each accepted instruction's result and pushes it to a scoreboard queue.
// The monitor pops and compares an entry on every output transfer. Directed
// steps also check reset values, back-pressure holding and the MULL timing
// and reset abort (EX_MULL_EN) or MULL rejection (default build).

module tb_ex_pipe;

   localparam int         W     = 32;
   localparam logic [7:0] RNONE = 8'h0F;

   typedef struct {
      logic [7:0]   icode;
      logic [W-1:0] valE;
      logic [W-1:0] valA;
      logic [7:0]   dstE;
      logic         cnd;
      logic [2:0]   cc;
      logic         err;
   } expT;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   expT  sb[$];
   logic [2:0] modelCc;

   ex_pipe_if #(.WIDTH(W)) bus ();

   ex_pipe #(.WIDTH(W), .RNONE(RNONE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // The free-running clock has a 10-unit period.
   always #5 clk = ~clk;

   // This task runs one comparison. A failed comparison counts against bad
   // and reports the tag with the observed and expected values.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // This task holds the reference model. It predicts the output of one
   // accepted instruction from the model's cc value, pushes that prediction
   // and updates the model cc.
   task automatic pushExpected(input logic [7:0] ic, input logic [7:0] fn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [7:0] dst);
      expT e;
      logic zf, sf, of, cond, upd, o;
      logic [2*W-1:0] prod;
      zf = modelCc[2]; sf = modelCc[1]; of = modelCc[0];
      case (fn)
         8'd0: cond = 1'b1;
         8'd1: cond = (sf ^ of) | zf;
         8'd2: cond = sf ^ of;
         8'd3: cond = zf;
         8'd4: cond = !zf;
         8'd5: cond = !(sf ^ of);
         8'd6: cond = !(sf ^ of) && !zf;
         default: cond = 1'b0;
      endcase
      e.icode = ic; e.valA = a; e.dstE = dst; e.cnd = 1'b1; e.err = 1'b0;
      e.valE = '0; upd = 1'b0; o = 1'b0;
      case (ic)
         8'h00, 8'h01: e.valE = '0;
         8'h02: begin
            e.valE = a; e.cnd = cond; e.err = (fn > 8'd6);
            if (!cond) e.dstE = RNONE;
         end
         8'h03: e.valE = c;
         8'h04, 8'h05: e.valE = b + c;
         8'h06: begin
            upd = 1'b1;
            case (fn)
               8'd0: begin e.valE = b + a; o = (a[W-1] == b[W-1]) && (e.valE[W-1] != a[W-1]); end
               8'd1: begin e.valE = b - a; o = (a[W-1] != b[W-1]) && (e.valE[W-1] != b[W-1]); end
               8'd2: e.valE = b & a;
               8'd3: e.valE = b ^ a;
`ifdef EX_MULL_EN
               8'd4: begin
                  prod = {{W{1'b0}}, b} * {{W{1'b0}}, a};
                  e.valE = prod[W-1:0];
                  o = (prod[2*W-1:W] != '0);
               end
`endif
               default: e.err = 1'b1;
            endcase
         end
         8'h07: begin e.valE = c; e.cnd = cond; e.err = (fn > 8'd6); end
         8'h08, 8'h0A: e.valE = b - 4;
         8'h09, 8'h0B: e.valE = b + 4;
         default: e.err = 1'b1;
      endcase
      if (e.err) begin
         e.valE = '0; e.dstE = RNONE; e.cnd = 1'b0; upd = 1'b0;
      end
      if (upd) modelCc = {(e.valE == '0), e.valE[W-1], o};
      e.cc = modelCc;
      sb.push_back(e);
   endtask

   // This task presents one instruction and keeps it valid until the stage
   // accepts it, giving up after a fixed number of cycles. It returns one
   // time unit after the accepting edge.
   task automatic applyStimulus(input logic [7:0] ic, input logic [7:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [7:0] dst);
      bus.in_valid = 1'b1;
      bus.icode_i = ic; bus.ifun_i = fn;
      bus.valA_i = a; bus.valB_i = b; bus.valC_i = c; bus.dstE_i = dst;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (bus.in_ready === 1'b1) begin
            pushExpected(ic, fn, a, b, c, dst);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("acceptTimeout", 1'b0, 1'b1);
   endtask

   // This task waits until every predicted result has left the stage.
   task automatic waitDrain();
      for (int n = 0; n < 200; n++) begin
         if (sb.size() == 0 && bus.out_valid === 1'b0) return;
         @(posedge clk); #1;
      end
      checkOutput("drainTimeout", W'(sb.size()), '0);
   endtask

   // The monitor samples on the falling edge. It compares every result that
   // will transfer on the next rising edge against the oldest prediction.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL unexpectedOutput observed=%h expected=none", bus.valE_o);
         end else begin
            expT e;
            e = sb.pop_front();
            checkOutput("icode", W'(bus.icode_o), W'(e.icode));
            checkOutput("valE",  bus.valE_o,      e.valE);
            checkOutput("valA",  bus.valA_o,      e.valA);
            checkOutput("dstE",  W'(bus.dstE_o),  W'(e.dstE));
            checkOutput("cnd",   W'(bus.cnd_o),   W'(e.cnd));
            checkOutput("cc",    W'(bus.cc_o),    W'(e.cc));
            checkOutput("err",   W'(bus.err_o),   W'(e.err));
         end
      end
   end

   // This block holds the directed stimulus sequence.
   initial begin
      int cycles;
      logic leak;
      rst = 1'b1;
      modelCc = 3'b100;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.icode_i = '0; bus.ifun_i = '0; bus.dstE_i = '0;
      bus.valA_i = '0; bus.valB_i = '0; bus.valC_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("rstCc",       W'(bus.cc_o),      W'(3'b100));
      checkOutput("rstOutValid", W'(bus.out_valid), '0);
      checkOutput("rstDstE",     W'(bus.dstE_o),    W'(8'h0F));
      checkOutput("rstIcode",    W'(bus.icode_o),   W'(8'h01));
      checkOutput("rstValE",     bus.valE_o,        '0);
      checkOutput("rstErr",      W'(bus.err_o),     '0);
      checkOutput("rstInReady",  W'(bus.in_ready),  W'(1));
      @(posedge clk); #1;

      $display("[TB] directed arithmetic and condition codes");
      applyStimulus(8'h06, 8'd1, 32'd5, 32'd5, 32'd0, 8'd1);
      applyStimulus(8'h06, 8'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 8'd2);
      applyStimulus(8'h02, 8'd2, 32'h55, 32'd0, 32'd0, 8'd3);
      applyStimulus(8'h02, 8'd5, 32'h66, 32'd0, 32'd0, 8'd4);
      applyStimulus(8'h07, 8'd1, 32'd0, 32'd0, 32'h400, RNONE);
      applyStimulus(8'h06, 8'd1, 32'h80000000, 32'd1, 32'd0, 8'd5);
      applyStimulus(8'h07, 8'd6, 32'd0, 32'd0, 32'h500, RNONE);
      applyStimulus(8'h0A, 8'd0, 32'h11, 32'h100, 32'd0, 8'd4);
      applyStimulus(8'h0B, 8'd0, 32'h22, 32'hFC, 32'd0, 8'd4);
      applyStimulus(8'h08, 8'd0, 32'd0, 32'h0, 32'h700, 8'd4);
      applyStimulus(8'h09, 8'd0, 32'd0, 32'hFFFFFFFC, 32'd0, 8'd4);
      applyStimulus(8'h05, 8'd0, 32'd0, 32'h1000, 32'h24, 8'd6);
      applyStimulus(8'h00, 8'd0, 32'h9, 32'h9, 32'h9, 8'd7);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'h06, 8'($urandom_range(0, 3)), $urandom, $urandom, 32'd0, 8'(i));
         applyStimulus(8'h02, 8'($urandom_range(0, 6)), $urandom, 32'd0, 32'd0, 8'(i + 8));
      end
      waitDrain();

      $display("[TB] back-pressure hold");
      bus.out_ready = 1'b0;
      applyStimulus(8'h03, 8'd0, 32'hAA, 32'd0, 32'h1234, 8'd2);
      bus.in_valid = 1'b1;
      bus.icode_i = 8'h04; bus.ifun_i = 8'd0;
      bus.valA_i = 32'hBB; bus.valB_i = 32'h100; bus.valC_i = 32'h20; bus.dstE_i = RNONE;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("holdValid", W'(bus.out_valid), W'(1));
         checkOutput("holdReady", W'(bus.in_ready),  '0);
         checkOutput("holdValE",  bus.valE_o,        sb[0].valE);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      applyStimulus(8'h04, 8'd0, 32'hBB, 32'h100, 32'h20, RNONE);

      $display("[TB] invalid instructions");
      applyStimulus(8'h0C, 8'd0, 32'h1, 32'h2, 32'h3, 8'd1);
      applyStimulus(8'h07, 8'd7, 32'h1, 32'h2, 32'h3, 8'd1);
      applyStimulus(8'h02, 8'd9, 32'h1, 32'h2, 32'h3, 8'd1);
      applyStimulus(8'h06, 8'd5, 32'h1, 32'h2, 32'h3, 8'd1);
      applyStimulus(8'h06, 8'd4, 32'h10000, 32'h10001, 32'd0, 8'd3);
      waitDrain();

`ifdef EX_MULL_EN
      $display("[TB] multiply latency and reset abort");
      applyStimulus(8'h06, 8'd4, 32'h12345, 32'h6789, 32'd0, 8'd3);
      cycles = 0;
      leak = 1'b0;
      while (bus.out_valid !== 1'b1 && cycles < 200) begin
         if (bus.in_ready !== 1'b0) leak = 1'b1;
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("mulLatency",  W'(cycles), W'(W + 1));
      checkOutput("mulReadyLow", W'(leak),   '0);
      waitDrain();
      applyStimulus(8'h06, 8'd4, 32'hFFFF, 32'h3, 32'd0, 8'd6);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      void'(sb.pop_back());
      modelCc = 3'b100;
      #1;
      checkOutput("abortOutValid", W'(bus.out_valid), '0);
      checkOutput("abortCc",       W'(bus.cc_o),      W'(3'b100));
      checkOutput("abortInReady",  W'(bus.in_ready),  W'(1));
      applyStimulus(8'h06, 8'd0, 32'd2, 32'd3, 32'd0, 8'd1);
      waitDrain();
`endif

      checkOutput("scoreboardEmpty", W'(sb.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
